// File: rtl/io_register_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_register_bank: memory-mapped output channels, synchronised input port |
// | with rising-edge capture and irq, and a prescaled free-running timer.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module io_register_bank #(
  parameter int NUM_OUT_CHANNELS = 2,
  parameter int OUT_WIDTH        = 8,
  parameter int IN_WIDTH         = 8,
  parameter int DATA_WIDTH       = 16,
  parameter int INDEX_WIDTH      = 7,
  parameter int BASE_INDEX       = 0,
  parameter int TIMER_PRESCALE   = 1000
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [INDEX_WIDTH-1:0]               register_index,
  input  logic                                 register_read,
  input  logic                                 register_write,
  input  logic [DATA_WIDTH-1:0]                register_write_value,
  output logic [DATA_WIDTH-1:0]                register_read_value,
  output logic [NUM_OUT_CHANNELS*OUT_WIDTH-1:0] out,
  input  logic [IN_WIDTH-1:0]                  in,
  output logic                                 irq
);

  localparam int c_AW = INDEX_WIDTH + 1;
  localparam int c_PW = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;

  localparam logic [c_AW-1:0] c_BASE       = c_AW'(BASE_INDEX);
  localparam logic [c_AW-1:0] c_OFF_IN     = c_AW'(NUM_OUT_CHANNELS);
  localparam logic [c_AW-1:0] c_OFF_EDGE   = c_AW'(NUM_OUT_CHANNELS + 1);
  localparam logic [c_AW-1:0] c_OFF_IRQEN  = c_AW'(NUM_OUT_CHANNELS + 2);
  localparam logic [c_AW-1:0] c_OFF_TIMER  = c_AW'(NUM_OUT_CHANNELS + 3);
  localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(TIMER_PRESCALE - 1);

  logic [NUM_OUT_CHANNELS-1:0][OUT_WIDTH-1:0] r_out;
  logic [IN_WIDTH-1:0]   r_sync1;
  logic [IN_WIDTH-1:0]   r_sync2;
  logic [IN_WIDTH-1:0]   r_prev;
  logic [IN_WIDTH-1:0]   r_edge;
  logic [IN_WIDTH-1:0]   r_irq_en;
  logic [DATA_WIDTH-1:0] r_timer;
  logic [c_PW-1:0]       r_presc;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_irq;

  logic [c_AW-1:0]       w_idx_ext;
  logic [c_AW-1:0]       w_off;
  logic                  w_valid;
  logic                  w_wr_edge;
  logic                  w_wr_irqen;
  logic                  w_wr_timer;
  logic                  w_tick;
  logic [IN_WIDTH-1:0]   w_rise;
  logic [IN_WIDTH-1:0]   w_clr;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Widen by one bit so indices below the base can be rejected before subtracting.
  assign w_idx_ext  = {1'b0, register_index};
  assign w_off      = w_idx_ext - c_BASE;
  assign w_valid    = (w_idx_ext >= c_BASE) && (w_off <= c_OFF_TIMER);
  assign w_wr_edge  = register_write && w_valid && (w_off == c_OFF_EDGE);
  assign w_wr_irqen = register_write && w_valid && (w_off == c_OFF_IRQEN);
  assign w_wr_timer = register_write && w_valid && (w_off == c_OFF_TIMER);
  assign w_tick     = (r_presc == c_PRESC_LAST);
  assign w_rise     = r_sync2 & ~r_prev;
  assign w_clr      = w_wr_edge ? register_write_value[IN_WIDTH-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    if (w_valid) begin
      for (int k = 0; k < NUM_OUT_CHANNELS; k++) begin
        if (w_off == c_AW'(k)) w_rdata[OUT_WIDTH-1:0] = r_out[k];
      end
      if (w_off == c_OFF_IN)    w_rdata[IN_WIDTH-1:0] = r_sync2;
      if (w_off == c_OFF_EDGE)  w_rdata[IN_WIDTH-1:0] = r_edge;
      if (w_off == c_OFF_IRQEN) w_rdata[IN_WIDTH-1:0] = r_irq_en;
      if (w_off == c_OFF_TIMER) w_rdata = r_timer;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out    <= '0;
      r_irq_en <= '0;
      r_rdata  <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT_CHANNELS; k++) begin
        if (register_write && w_valid && (w_off == c_AW'(k)))
          r_out[k] <= register_write_value[OUT_WIDTH-1:0];
      end
      if (w_wr_irqen) r_irq_en <= register_write_value[IN_WIDTH-1:0];
      if (register_read) r_rdata <= w_rdata;
    end
  end

  // Set wins over a coincident write-one-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_edge  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= (r_edge & ~w_clr) | w_rise;
      r_irq   <= |(r_edge & r_irq_en);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
      r_presc <= '0;
    end else if (w_wr_timer) begin
      r_timer <= register_write_value;
      r_presc <= '0;
    end else if (w_tick) begin
      r_timer <= r_timer + 1'b1;
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign out                 = r_out;
  assign register_read_value = r_rdata;
  assign irq                 = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_io_register_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_io_register_bank: randomized and directed bench for io_register_bank  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_io_register_bank;
  localparam int N    = 2;
  localparam int OW   = 8;
  localparam int IW   = 8;
  localparam int DW   = 16;
  localparam int XW   = 7;
  localparam int BASE = 8;
  localparam int PRE  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [XW-1:0]     register_index = '0;
  logic              register_read = 1'b0;
  logic              register_write = 1'b0;
  logic [DW-1:0]     register_write_value = '0;
  logic [DW-1:0]     register_read_value;
  logic [N*OW-1:0]   out;
  logic [IW-1:0]     pins = '0;
  logic              irq;

  io_register_bank #(
    .NUM_OUT_CHANNELS(N), .OUT_WIDTH(OW), .IN_WIDTH(IW), .DATA_WIDTH(DW),
    .INDEX_WIDTH(XW), .BASE_INDEX(BASE), .TIMER_PRESCALE(PRE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .register_index(register_index), .register_read(register_read),
    .register_write(register_write), .register_write_value(register_write_value),
    .register_read_value(register_read_value), .out(out), .in(pins), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int m_out[N];
  int m_sync1, m_sync2, m_prev, m_edge, m_en, m_timer, m_cnt, m_rdata, m_irq;

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_out[k] = 0;
    m_sync1 = 0; m_sync2 = 0; m_prev = 0; m_edge = 0; m_en = 0;
    m_timer = 0; m_cnt = 0; m_rdata = 0; m_irq = 0;
  endtask

  function automatic int rd_val(input int off);
    if (off < N)      return m_out[off];
    if (off == N)     return m_sync2;
    if (off == N + 1) return m_edge;
    if (off == N + 2) return m_en;
    if (off == N + 3) return m_timer;
    return 0;
  endfunction

  // One bus cycle: drive at negedge, advance model at posedge, compare just after.
  task automatic cyc(input int idx, input bit rd, input bit wr, input int wd);
    int off, clr, n_edge, n_irq;
    bit valid;
    logic [N*OW-1:0] exp_out;
    register_index       = idx[XW-1:0];
    register_read        = rd;
    register_write       = wr;
    register_write_value = wd[DW-1:0];
    @(posedge clk);
    off   = idx - BASE;
    valid = (idx >= BASE) && (off <= N + 3);
    if (rd) m_rdata = valid ? rd_val(off) : 0;
    n_irq  = ((m_edge & m_en) != 0) ? 1 : 0;
    clr    = (wr && valid && off == N + 1) ? (wd & 'hFF) : 0;
    n_edge = ((m_edge & ~clr) | (m_sync2 & ~m_prev)) & 'hFF;
    if (wr && valid && off < N)      m_out[off] = wd & 'hFF;
    if (wr && valid && off == N + 2) m_en = wd & 'hFF;
    if (wr && valid && off == N + 3) begin
      m_timer = wd & 'hFFFF;
      m_cnt   = 0;
    end else begin
      m_cnt++;
      if (m_cnt == PRE) begin
        m_cnt   = 0;
        m_timer = (m_timer + 1) & 'hFFFF;
      end
    end
    m_prev  = m_sync2;
    m_sync2 = m_sync1;
    m_sync1 = int'(pins);
    m_edge  = n_edge;
    m_irq   = n_irq;
    #1;
    for (int k = 0; k < N; k++) exp_out[k*OW +: OW] = m_out[k][OW-1:0];
    check("out", 32'(out), 32'(exp_out));
    check("rdata", 32'(register_read_value), m_rdata);
    check("irq", 32'(irq), m_irq);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 0);
    check("rst_rdata", 32'(register_read_value), 0);
    check("rst_irq", 32'(irq), 0);
    reset_n = 1'b1;

    // Output channel write/read, out-of-range and below-base accesses
    cyc(BASE + 1, 0, 1, 'h1A5);
    check("out_ch1", 32'(out), 32'h0000_A500);
    cyc(BASE + 1, 1, 0, 0);
    check("rd_ch1", 32'(register_read_value), 32'h00A5);
    cyc(BASE + 7, 1, 0, 0);
    check("rd_hole", 32'(register_read_value), 0);
    cyc(BASE - 1, 0, 1, 'hFF);
    cyc(BASE - 1, 1, 0, 0);
    check("rd_below", 32'(register_read_value), 0);

    // Edge capture, irq assert and W1C deassert
    cyc(BASE + N + 2, 0, 1, 'h08);
    pins[3] = 1'b1;
    idle(3);
    cyc(BASE + N + 1, 1, 0, 0);
    check("edge_bit3", 32'(register_read_value), 32'h0008);
    check("irq_set", 32'(irq), 1);
    cyc(BASE + N + 1, 0, 1, 'h08);
    idle(1);
    check("irq_clr", 32'(irq), 0);

    // Set beats clear in the same cycle
    pins[0] = 1'b1;
    idle(2);
    cyc(BASE + N + 1, 0, 1, 'h01);
    cyc(BASE + N + 1, 1, 0, 0);
    check("set_wins", 32'(register_read_value) & 32'h1, 1);

    // Timer wrap and write-on-tick
    cyc(BASE + N + 3, 0, 1, 'hFFFE);
    cyc(BASE + N + 3, 1, 0, 0);
    check("tmr_fffe", 32'(register_read_value), 32'hFFFE);
    idle(3);
    cyc(BASE + N + 3, 1, 0, 0);
    check("tmr_ffff", 32'(register_read_value), 32'hFFFF);
    idle(3);
    cyc(BASE + N + 3, 1, 0, 0);
    check("tmr_wrap", 32'(register_read_value), 0);
    guard = 0;
    while (m_cnt != PRE - 1 && guard < 10) begin
      idle(1);
      guard++;
    end
    check("tick_found", guard < 10 ? 1 : 0, 1);
    cyc(BASE + N + 3, 0, 1, 'h1234);
    cyc(BASE + N + 3, 1, 0, 0);
    check("tmr_wr_tick", 32'(register_read_value), 32'h1234);

    // Read and write of the same register in one cycle
    cyc(BASE, 0, 1, 'h11);
    cyc(BASE, 1, 1, 'h22);
    check("rw_old", 32'(register_read_value), 32'h0011);
    cyc(BASE, 1, 0, 0);
    check("rw_new", 32'(register_read_value), 32'h0022);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3, 0) == 0) pins = IW'($urandom);
      cyc(int'($urandom_range(BASE + N + 5, BASE - 2)), 1'($urandom), ($urandom_range(2, 0) == 0),
          int'($urandom));
    end

    // Asynchronous reset during a pending write
    cyc(BASE, 0, 1, 'h5A);
    cyc(BASE, 1, 0, 0);
    register_index = XW'(BASE);
    register_write = 1'b1;
    register_write_value = 16'h00C3;
    #2 reset_n = 1'b0;
    #1;
    check("arst_out", 32'(out), 0);
    check("arst_rdata", 32'(register_read_value), 0);
    check("arst_irq", 32'(irq), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    register_write = 1'b0;
    reset_n = 1'b1;
    cyc(BASE, 1, 0, 0);
    check("post_rst_rd", 32'(register_read_value), 0);
    cyc(BASE + N + 2, 1, 0, 0);
    check("post_rst_en", 32'(register_read_value), 0);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
